// File: rtl/serial_add_seq.sv
// ---------------------------------------------------------------------------
// serial_add_seq
//
// Bit-serial addition sequencer wrapped around an external full_adder stage.
// Two WIDTH-bit operands and a carry-in are captured on an accepted start.
// One bit pair per cycle, LSB first, is presented to the full adder together
// with the registered carry. The returned sum bit is shifted into a result
// register and the returned carry is fed back for the next bit. After WIDTH
// bits the full sum and carry-out are published and done pulses for one cycle.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   start     in   1      request, sampled only in IDLE
//   op_a      in   WIDTH  operand A, captured on accepted start
//   op_b      in   WIDTH  operand B, captured on accepted start
//   cin       in   1      carry-in, captured on accepted start
//   fa_a      out  1      current bit of A to the full adder (0 outside RUN)
//   fa_b      out  1      current bit of B to the full adder (0 outside RUN)
//   fa_c      out  1      carry register to the full adder (0 outside RUN)
//   fa_sum    in   1      full adder sum, combinational from fa_a/fa_b/fa_c
//   fa_carry  in   1      full adder carry, combinational from fa_a/fa_b/fa_c
//   busy      out  1      high while bits are being processed
//   done      out  1      one-cycle completion pulse
//   sum       out  WIDTH  result, held until overwritten by the next completion
//   cout      out  1      final carry, held like sum
// ---------------------------------------------------------------------------
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c,
    input  logic             fa_sum,
    input  logic             fa_carry,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic [WIDTH-1:0] sum_reg, sum_next;
    logic             carry_reg, carry_next;
    logic             cout_reg, cout_next;
    logic [CW-1:0]    cnt_reg, cnt_next;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            sum_reg    <= '0;
            carry_reg  <= 1'b0;
            cout_reg   <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            result_reg <= result_next;
            sum_reg    <= sum_next;
            carry_reg  <= carry_next;
            cout_reg   <= cout_next;
            cnt_reg    <= cnt_next;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_next  = state_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        result_next = result_reg;
        sum_next    = sum_reg;
        carry_next  = carry_reg;
        cout_next   = cout_reg;
        cnt_next    = cnt_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_next      = op_a;
                    b_next      = op_b;
                    carry_next  = cin;
                    result_next = '0;
                    cnt_next    = '0;
                    state_next  = RUN;
                end
            end
            RUN: begin
                a_next      = a_reg >> 1;
                b_next      = b_reg >> 1;
                carry_next  = fa_carry;
                result_next = {fa_sum, result_reg[WIDTH-1:1]};
                cnt_next    = cnt_reg + CW'(1);
                if (cnt_reg == LAST_BIT) begin
                    // Publish only on the final bit so partial results never
                    // appear on sum.
                    sum_next   = {fa_sum, result_reg[WIDTH-1:1]};
                    cout_next  = fa_carry;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);
    assign fa_a = busy & a_reg[0];
    assign fa_b = busy & b_reg[0];
    assign fa_c = busy & carry_reg;
    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule
